// File: rtl/torso_audio_pkg.sv
// torso_audio_pkg: shared constants, state type and LFSR step for the tone sequencer
package torso_audio_pkg;
    localparam int IDX_BITS = 5;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    typedef enum logic [1:0] {OFF, GAP, PLAY} state_e;
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction
endpackage

// File: rtl/tone_channel.sv
// tone_channel: phase-accumulator square wave for one pitch index
module tone_channel import torso_audio_pkg::*; #(
    parameter int ACC_BITS = 24,
    parameter int BASE_INC = 268,
    parameter int STEP_INC = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                run,
    input  logic [IDX_BITS-1:0] idx,
    output logic                sq
);
    logic [ACC_BITS-1:0] acc_q, acc_d, inc;
    always_comb begin
        inc = ACC_BITS'(BASE_INC) + ACC_BITS'(idx) * ACC_BITS'(STEP_INC);
        acc_d = clr ? '0 : run ? acc_q + inc : acc_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else acc_q <= acc_d;
    end
    assign sq = acc_q[ACC_BITS-1];
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: LFSR-driven multi-channel tone player mixed into one PWM pin
module tone_sequencer import torso_audio_pkg::*; #(
    parameter int          CHANNELS   = 2,
    parameter int          PWM_BITS   = 8,
    parameter int          ACC_BITS   = 24,
    parameter int          GAP_CYCLES = 250000,
    parameter int          BASE_INC   = 268,
    parameter int          STEP_INC   = 40,
    parameter logic [31:0] LFSR_SEED  = 32'h00000001
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         sec,
    input  logic                         mute,
    output logic                         pwm,
    output logic [CHANNELS*IDX_BITS-1:0] tone_idx,
    output logic                         playing
);
    localparam int AMP = (2**PWM_BITS - 1) / CHANNELS;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int PCW = $clog2(CHANNELS + 1);
    state_e state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [CHANNELS*IDX_BITS-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PWM_BITS-1:0] cnt_q, level_q, level_d;
    logic [PCW-1:0] pc;
    logic [CHANNELS-1:0] sq;
    logic pwm_q, playing_q, accept, gap_done, clr, run;
    // en low overrides a coincident sec, so acceptance needs both
    assign accept = en && sec;
    assign gap_done = gap_q == GW'(GAP_CYCLES - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= OFF;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = !en ? OFF : accept ? GAP : state_q == OFF ? PLAY :
                  (state_q == GAP && !gap_done) ? GAP : PLAY;
    end
    always_comb begin
        run = state_q == PLAY;
        clr = !en || accept;
        lfsr_d = accept ? lfsr_next(lfsr_q) : lfsr_q;
        idx_d = accept ? lfsr_d[CHANNELS*IDX_BITS-1:0] : idx_q;
        gap_d = accept ? '0 : state_q == GAP ? gap_q + 1'b1 : gap_q;
        pc = '0;
        for (int i = 0; i < CHANNELS; i++) pc = pc + PCW'(sq[i]);
        level_d = (run && !mute) ? PWM_BITS'(AMP * pc) : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
            idx_q <= '0;
            gap_q <= '0;
            cnt_q <= '0;
            level_q <= '0;
            pwm_q <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            idx_q <= idx_d;
            gap_q <= gap_d;
            cnt_q <= cnt_q + 1'b1;
            level_q <= level_d;
            pwm_q <= cnt_q < level_q;
            playing_q <= state_d == PLAY;
        end
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        tone_channel #(.ACC_BITS(ACC_BITS), .BASE_INC(BASE_INC), .STEP_INC(STEP_INC)) u_ch (
            .clk(clk), .rst(rst), .clr(clr), .run(run),
            .idx(idx_q[c*IDX_BITS +: IDX_BITS]), .sq(sq[c])
        );
    end
    assign pwm = pwm_q;
    assign tone_idx = idx_q;
    assign playing = playing_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench for tone_sequencer with a shortened gap and accumulator
module tb_tone_sequencer;
    localparam int GAP = 40;
    logic clk = 0, rst = 0, en = 0, sec = 0, mute = 0;
    logic pwm, playing;
    logic [9:0] tone_idx;
    logic [31:0] lfsr_m = 32'h1;
    logic [9:0] sb_q[$];
    int total = 0, bad = 0, h, k;

    tone_sequencer #(.CHANNELS(2), .PWM_BITS(8), .ACC_BITS(20), .GAP_CYCLES(GAP),
                     .BASE_INC(268), .STEP_INC(40), .LFSR_SEED(32'h1)) dut (
        .clk(clk), .rst(rst), .en(en), .sec(sec), .mute(mute),
        .pwm(pwm), .tone_idx(tone_idx), .playing(playing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] v);
        step = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sec;
        if (en) lfsr_m = step(lfsr_m);
        sb_q.push_back(lfsr_m[9:0]);
        sec = 1;
        tick;
        sec = 0;
        chk("idx_after_sec", {22'h0, tone_idx}, {22'h0, sb_q.pop_front()});
    endtask

    task automatic count_pwm(output int n);
        n = 0;
        repeat (256) begin
            tick;
            n += int'(pwm);
        end
    endtask

    task automatic wait_play(output int n);
        n = 0;
        while (!playing && n < 5000) begin
            tick;
            n++;
        end
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_playing", {31'h0, playing}, 0);
        chk("rst_pwm", {31'h0, pwm}, 0);
        chk("rst_idx", {22'h0, tone_idx}, 0);
        @(negedge clk);
        rst = 1;
        tick;
        chk("off_hold", {31'h0, playing}, 0);
        en = 1;
        tick;
        chk("play_no_sec", {31'h0, playing}, 1);
        chk("idx_zero", {22'h0, tone_idx}, 0);
        repeat (2500) tick;
        count_pwm(h);
        chk("duty_both", h, 254);
        mute = 1;
        repeat (2) tick;
        chk("mute_fast", {31'h0, pwm}, 0);
        count_pwm(h);
        chk("duty_mute", h, 0);
        mute = 0;
        pulse_sec;
        chk("gap_low", {31'h0, playing}, 0);
        chk("idx_first", {22'h0, tone_idx}, 10'h003);
        wait_play(k);
        chk("gap_len", k, GAP);
        repeat (1500) tick;
        count_pwm(h);
        chk("duty_ch0", h, 127);
        repeat (1244) tick;
        count_pwm(h);
        chk("duty_ch1", h, 127);
        pulse_sec;
        repeat (20) tick;
        pulse_sec;
        wait_play(k);
        chk("gap_restart", k, GAP);
        repeat (1000) tick;
        en = 0;
        pulse_sec;
        chk("enfall_playing", {31'h0, playing}, 0);
        repeat (2) tick;
        chk("enfall_pwm", {31'h0, pwm}, 0);
        repeat (5) tick;
        chk("off_stay", {31'h0, playing}, 0);
        en = 1;
        tick;
        chk("replay", {31'h0, playing}, 1);
        chk("idx_kept", {22'h0, tone_idx}, {22'h0, lfsr_m[9:0]});
        pulse_sec;
        wait_play(k);
        chk("gap_after_off", k, GAP);
        repeat (1500) tick;
        #3;
        rst = 0;
        #1;
        chk("arst_pwm", {31'h0, pwm}, 0);
        chk("arst_playing", {31'h0, playing}, 0);
        chk("arst_idx", {22'h0, tone_idx}, 0);
        @(negedge clk);
        rst = 1;
        lfsr_m = 32'h1;
        tick;
        pulse_sec;
        chk("idx_reseed", {22'h0, tone_idx}, 10'h003);
        wait_play(k);
        chk("gap_reseed", k, GAP);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
